// File: rtl/vga_pkg.sv
// Shared VGA raster package: default 800x600@72 timing, coordinate widths and
// the helper used to form line/frame totals from porch/sync/visible lengths.
package vga_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int X_TOTAL_MAX = 2047;
    localparam int Y_TOTAL_MAX = 1023;

    localparam int DEF_H_VIS  = 800;
    localparam int DEF_H_FP   = 56;
    localparam int DEF_H_SYNC = 120;
    localparam int DEF_H_BP   = 64;
    localparam int DEF_V_VIS  = 600;
    localparam int DEF_V_FP   = 37;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 23;

    function automatic int vga_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Enable-gated shift register with synchronous active-low reset; keeps the
// sync/visible decodes aligned with the downstream pixel pipeline.
module pix_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enable; clear every stage on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, x/y counters, sync/visible decode
// through a pixel-tick delay line. Optional macro VGA_TIMING_FRAME_CNT_EN adds o_frame_count.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS      = DEF_H_VIS,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_VIS      = DEF_V_VIS,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   CLK_DIV    = 1,
    parameter int   SYNC_DELAY = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    output logic [X_W-1:0] o_x_count,
    output logic [Y_W-1:0] o_y_count,
    output logic           o_pix_ce,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_video_on,
    output logic           o_line_start,
    output logic           o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]     o_frame_count
`endif
);

    localparam int H_TOTAL = vga_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_VIS, V_FP, V_SYNC, V_BP);

    localparam logic [X_W-1:0] X_MAX  = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] X_VIS  = X_W'(H_VIS);
    localparam logic [Y_W-1:0] Y_VIS  = Y_W'(V_VIS);
    localparam logic [X_W-1:0] HS_BEG = X_W'(H_VIS + H_FP);
    localparam logic [X_W-1:0] HS_END = X_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0] VS_BEG = Y_W'(V_VIS + V_FP);
    localparam logic [Y_W-1:0] VS_END = Y_W'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [1:0]     P_MAX  = 2'(CLK_DIV - 1);

    if (H_TOTAL > X_TOTAL_MAX || V_TOTAL > Y_TOTAL_MAX || CLK_DIV < 1 || CLK_DIV > 4 ||
        SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_param_err
        $error("vga_timing_gen: timing parameters out of range");
    end

    logic [1:0]     r_presc;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_line_start;
    logic           r_frame_start;
    logic           r_run;

    logic           w_pix_ce;
    logic           w_x_last;
    logic           w_y_last;
    logic [1:0]     w_presc_nxt;
    logic [X_W-1:0] w_x_nxt;
    logic [Y_W-1:0] w_y_nxt;
    logic [2:0]     w_raw;
    logic [2:0]     w_dly;
    logic [2:0]     w_out;

    assign w_pix_ce = (r_presc == 2'd0);
    assign w_x_last = (r_x == X_MAX);
    assign w_y_last = (r_y == Y_MAX);

    // Next prescaler and raster position; wrap by compare against the totals.
    always_comb begin
        w_presc_nxt = r_presc;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        if (r_presc == P_MAX) begin
            w_presc_nxt = 2'd0;
        end else begin
            w_presc_nxt = r_presc + 2'd1;
        end
        if (w_pix_ce) begin
            if (w_x_last) begin
                w_x_nxt = '0;
                if (w_y_last) begin
                    w_y_nxt = '0;
                end else begin
                    w_y_nxt = r_y + 10'd1;
                end
            end else begin
                w_x_nxt = r_x + 11'd1;
            end
        end else begin
            w_x_nxt = r_x;
            w_y_nxt = r_y;
        end
    end

    // Counter state; wrap pulses are registered so they coincide with the wrapped value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc       <= 2'd0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_presc       <= w_presc_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_line_start  <= w_pix_ce & w_x_last;
            r_frame_start <= w_pix_ce & w_x_last & w_y_last;
            r_run         <= 1'b1;
        end
    end

    // Raw {hsync, vsync, visible} decode of the undelayed coordinates.
    always_comb begin
        w_raw    = 3'b000;
        w_raw[2] = (r_x >= HS_BEG) && (r_x <= HS_END);
        w_raw[1] = (r_y >= VS_BEG) && (r_y <= VS_END);
        w_raw[0] = (r_x < X_VIS) && (r_y < Y_VIS);
    end

    if (SYNC_DELAY > 0) begin : g_dly
        pix_delay_line #(
            .DEPTH(SYNC_DELAY),
            .WIDTH(3)
        ) u_dly (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_en   (w_pix_ce),
            .i_data (w_raw),
            .o_data (w_dly)
        );
    end else begin : g_nodly
        assign w_dly = w_raw;
    end

    // r_run keeps the zero-delay decode inactive on the clk right after reset.
    assign w_out = r_run ? w_dly : 3'b000;

    assign o_x_count     = r_x;
    assign o_y_count     = r_y;
    assign o_pix_ce      = w_pix_ce;
    assign o_hsync       = w_out[2] ? SYNC_POL : ~SYNC_POL;
    assign o_vsync       = w_out[1] ? SYNC_POL : ~SYNC_POL;
    assign o_video_on    = w_out[0];
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_count;

    // Frame counter advances together with the frame wrap, 255 -> 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_count <= 8'd0;
        end else if (w_pix_ce && w_x_last && w_y_last) begin
            r_frame_count <= r_frame_count + 8'd1;
        end else begin
            r_frame_count <= r_frame_count;
        end
    end

    assign o_frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: random reset stimulus drives four generator configurations;
// a tick-count reference model predicts every output each clk.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, div, dly, pol;
    } cfg_t;

    typedef struct {
        int x, y, fc;
        bit pce, hs, vs, vo, ls, fs;
    } exp_t;

    localparam int NCYC = 45000;
    localparam int NINST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [10:0] xs  [NINST];
    logic [9:0]  ys  [NINST];
    logic        pce [NINST];
    logic        hsy [NINST];
    logic        vsy [NINST];
    logic        von [NINST];
    logic        lst [NINST];
    logic        fst [NINST];
    logic [7:0]  fcn [NINST];

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   c_cnt    = 0;

    always #5 clk = ~clk;

`ifdef VGA_TIMING_FRAME_CNT_EN
    `define FC_PORT(k) , .o_frame_count(fcn[k])
`else
    `define FC_PORT(k)
`endif

    vga_timing_gen #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .SYNC_POL(1'b1), .CLK_DIV(1), .SYNC_DELAY(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .o_x_count(xs[0]), .o_y_count(ys[0]), .o_pix_ce(pce[0]),
        .o_hsync(hsy[0]), .o_vsync(vsy[0]), .o_video_on(von[0]), .o_line_start(lst[0]),
        .o_frame_start(fst[0]) `FC_PORT(0));

    vga_timing_gen #(.H_VIS(6), .H_FP(1), .H_SYNC(2), .H_BP(3), .V_VIS(4), .V_FP(2), .V_SYNC(1), .V_BP(2),
                     .SYNC_POL(1'b0), .CLK_DIV(2), .SYNC_DELAY(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .o_x_count(xs[1]), .o_y_count(ys[1]), .o_pix_ce(pce[1]),
        .o_hsync(hsy[1]), .o_vsync(vsy[1]), .o_video_on(von[1]), .o_line_start(lst[1]),
        .o_frame_start(fst[1]) `FC_PORT(1));

    vga_timing_gen #(.H_VIS(3), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .SYNC_POL(1'b1), .CLK_DIV(4), .SYNC_DELAY(7)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .o_x_count(xs[2]), .o_y_count(ys[2]), .o_pix_ce(pce[2]),
        .o_hsync(hsy[2]), .o_vsync(vsy[2]), .o_video_on(von[2]), .o_line_start(lst[2]),
        .o_frame_start(fst[2]) `FC_PORT(2));

    vga_timing_gen u_d (
        .i_clk(clk), .i_rst_n(rst_n), .o_x_count(xs[3]), .o_y_count(ys[3]), .o_pix_ce(pce[3]),
        .o_hsync(hsy[3]), .o_vsync(vsy[3]), .o_video_on(von[3]), .o_line_start(lst[3]),
        .o_frame_start(fst[3]) `FC_PORT(3));

`ifndef VGA_TIMING_FRAME_CNT_EN
    initial for (int k = 0; k < NINST; k++) fcn[k] = 8'd0;
`endif

    function automatic cfg_t cfg(input int k);
        cfg_t p;
        case (k)
            0:       p = '{8, 2, 3, 2, 5, 1, 2, 1, 1, 0, 1};
            1:       p = '{6, 1, 2, 3, 4, 2, 1, 2, 2, 2, 0};
            2:       p = '{3, 1, 1, 1, 2, 1, 1, 1, 4, 7, 1};
            default: p = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 2, 1};
        endcase
        return p;
    endfunction

    // Expected outputs after c running clks since reset: everything follows from the tick count.
    function automatic exp_t model(input int c, input cfg_t p);
        exp_t e;
        int ht, vt, n, m, mx, my;
        bit tick, act, hr, vr, vor;
        ht   = p.hv + p.hf + p.hs + p.hb;
        vt   = p.vv + p.vf + p.vs + p.vb;
        n    = (c + p.div - 1) / p.div;
        tick = (c > 0) && ((c - 1) % p.div == 0);
        e.x   = n % ht;
        e.y   = (n / ht) % vt;
        e.pce = (c % p.div) == 0;
        e.ls  = tick && (n % ht == 0);
        e.fs  = tick && (n % (ht * vt) == 0);
        e.fc  = (n / (ht * vt)) % 256;
        act   = (c > 0) && (n >= p.dly);
        hr = 1'b0; vr = 1'b0; vor = 1'b0;
        if (act) begin
            m   = n - p.dly;
            mx  = m % ht;
            my  = (m / ht) % vt;
            hr  = (mx >= p.hv + p.hf) && (mx < p.hv + p.hf + p.hs);
            vr  = (my >= p.vv + p.vf) && (my < p.vv + p.vf + p.vs);
            vor = (mx < p.hv) && (my < p.vv);
        end
        e.hs = hr ? (p.pol != 0) : (p.pol == 0);
        e.vs = vr ? (p.pol != 0) : (p.pol == 0);
        e.vo = vor;
        return e;
    endfunction

    // Monitor: after each edge pop one expectation per instance and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() >= NINST) begin
                for (int k = 0; k < NINST; k++) begin
                    exp_t e, a;
                    bit ok;
                    e = q.pop_front();
                    a.x = int'(xs[k]); a.y = int'(ys[k]); a.fc = int'(fcn[k]);
                    a.pce = pce[k]; a.hs = hsy[k]; a.vs = vsy[k]; a.vo = von[k];
                    a.ls = lst[k]; a.fs = fst[k];
                    ok = (a.x == e.x) && (a.y == e.y) && (a.pce == e.pce) && (a.hs == e.hs) &&
                         (a.vs == e.vs) && (a.vo == e.vo) && (a.ls == e.ls) && (a.fs == e.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
                    ok = ok && (a.fc == e.fc);
`endif
                    n_checks++;
                    if (!ok) begin
                        n_errors++;
                        $display("FAIL inst%0d t=%0t got x=%0d y=%0d ce=%0b hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b fc=%0d want x=%0d y=%0d ce=%0b hs=%0b vs=%0b vo=%0b ls=%0b fs=%0b fc=%0d",
                                 k, $time, a.x, a.y, a.pce, a.hs, a.vs, a.vo, a.ls, a.fs, a.fc,
                                 e.x, e.y, e.pce, e.hs, e.vs, e.vo, e.ls, e.fs, e.fc);
                    end
                end
            end
        end
    end

    // Driver: random reset pulses early on, then a long free run across many frames.
    initial begin
        int hold;
        hold = 5;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (hold == 0 && (cyc == 3000 || (cyc < 8000 && $urandom_range(999, 0) == 0))) begin
                hold = $urandom_range(6, 1);
                if (cyc == 3000) hold = 5;
            end
            if (hold > 0) begin
                rst_n = 1'b0;
                hold--;
                c_cnt = 0;
            end else begin
                rst_n = 1'b1;
                c_cnt++;
            end
            for (int k = 0; k < NINST; k++) q.push_back(model(c_cnt, cfg(k)));
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
